seven_segment_scan_controller: RTL and testbench
================================================

# seven_segment_scan_controller

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It cycles through the digits, drives one anode at a time with a blanking gap between digits to suppress ghosting, and applies PWM brightness within each digit slot. New digit values come in through a level-request/ack handshake into a shadow register. They are committed only at frame boundaries, so a frame never shows mixed data. It sits between the display-value producer and the board pins, and replaces free-running divider-driven scanning.

## Interface
- DIGITS, 4: number of digits scanned; must be ≥ 2.
- SLOT_WIDTH, 8: drive slot per digit is 2^SLOT_WIDTH cycles.
- BLANK_CYCLES, 4: all-anodes-off cycles before each digit's drive slot; must be ≥ 1.
- BRIGHT_WIDTH, 4: brightness resolution; must be ≤ SLOT_WIDTH.

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  scan enable; sampled synchronously.
- digitValues  in  4*DIGITS  hex nibble per digit; digit i = bits [4i+3:4i].
- load  in  1  level request to capture digitValues.
- brightness  in  BRIGHT_WIDTH  on-time fraction per slot, sampled every cycle.
- loadAck  out  1  one-cycle pulse when captured values go live.
- anodes  out  DIGITS  active-low digit enables; at most one low at a time.
- segments  out  7  active-low gfedcba, where bit 6 = g.
- frameStart  out  1  one-cycle pulse at the start of each frame.

## Operation
- State machine with three states:
  - IDLE: all anodes and segments high.
  - BLANK: anodes high; segments already show the current digit.
  - DRIVE: the current digit's anode is gated by PWM.
- State transitions:
  - IDLE→BLANK on the first edge with enable=1; digit index = 0; frameStart=1 for that cycle.
  - BLANK→DRIVE after exactly BLANK_CYCLES cycles.
  - DRIVE→BLANK after exactly 2^SLOT_WIDTH cycles, with digit index + 1. Index wraps DIGITS-1→0; frameStart pulses on the wrap.
  - Any state→IDLE on the edge where enable=0. Digit index and slot counter clear; the shadow register and its pending state are kept.
- PWM: a slot counter c (SLOT_WIDTH bits) runs 0..2^SLOT_WIDTH-1 in DRIVE.
  - The anode is low while c < brightness × 2^(SLOT_WIDTH−BRIGHT_WIDTH).
  - brightness=0 keeps the anode off for the whole slot. Maximum brightness gives (2^BRIGHT_WIDTH−1)/2^BRIGHT_WIDTH duty.
  - Unsigned compare; the product is SLOT_WIDTH bits wide with no overflow.
- Segment decode follows the standard hex font. Examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
- Handshake:
  - load=1 with no value pending: digitValues is captured into the shadow register and pending is set on that edge.
  - load while a value is pending is ignored, so the first capture wins.
  - Commit happens on the edge that enters BLANK for digit 0 (the frameStart edge), either from IDLE or from the wrap. On that edge, if pending is set: shadow→active, pending clears, and loadAck=1 for the following cycle.
  - load sampled on the commit edge is ignored because pending was still set at the start of the cycle.
  - load while enable=0 still captures; the commit waits for the next frame start.
- Reset sets all of the following:
  - state IDLE
  - anodes all 1, segments all 1
  - loadAck 0, frameStart 0
  - active register 0, pending clear, counters 0

## Timing
- Frame length = DIGITS × (BLANK_CYCLES + 2^SLOT_WIDTH) cycles.
- All outputs are registered; changes appear the cycle after the causal edge.
- The first anode goes low BLANK_CYCLES+1 cycles after enable rises (when brightness > 0).
- Maximum load-to-display latency is one frame plus BLANK_CYCLES.
- Reset asserted mid-frame forces outputs off immediately, without waiting for a clock. After release, scanning resumes from IDLE.
- A brightness change mid-slot takes effect on the next cycle's compare.

## Test plan
- Reset, then enable with DIGITS=4, SLOT_WIDTH=4, BLANK_CYCLES=2, brightness=15, active=0x0000. Required:
  - frameStart every 72 cycles.
  - anodes follow 1111×2, 1110×15, 1111×1 off, then 1111×2, 1101…
  - segments=1000000.
- Present load=1 with 0x8A10 mid-frame. Required:
  - digits keep showing 0 until the next frameStart edge.
  - loadAck is high for exactly one cycle after that edge.
  - digit0 shows 0 (1000000), digit1 shows 1, digit2 shows A, digit3 shows 8.
- Hold load high continuously with a changing digitValues. Required:
  - only the value sampled on the first edge is committed.
  - after the ack, the next capture commits one frame later.
- brightness=0 gives anodes stuck at all 1; brightness=4 with SLOT_WIDTH=4 gives exactly 4 low cycles per slot.
- Drop enable mid-DRIVE of digit 2. Required:
  - next cycle is all 1s.
  - re-enabling restarts at digit 0 with a frameStart pulse and commits any pending value.
- Assert reset asynchronously mid-slot with a value pending. Required:
  - outputs go to all 1s before the next edge.
  - pending clears, with no loadAck afterwards.

Source files
------------

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Each digit gets a blanking gap followed by a PWM-gated drive slot. New digit
// values are captured into a shadow register and go live only at frame start.
`timescale 1ns/1ps

module seven_segment_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int SLOT_WIDTH   = 8,
    parameter int BLANK_CYCLES = 4,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*DIGITS-1:0]     digitValues,
    input  logic                    load,
    input  logic [BRIGHT_WIDTH-1:0] brightness,
    output logic                    loadAck,
    output logic [DIGITS-1:0]       anodes,
    output logic [6:0]              segments,
    output logic                    frameStart
);

    localparam int DIGIT_BITS   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLANK_BITS   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BRIGHT_SHIFT = SLOT_WIDTH - BRIGHT_WIDTH;

    localparam logic [DIGIT_BITS-1:0] LAST_DIGIT = DIGIT_BITS'(DIGITS - 1);
    localparam logic [BLANK_BITS-1:0] LAST_BLANK = BLANK_BITS'(BLANK_CYCLES - 1);
    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT  = '1;

    // Elaboration-time sanity checks on the parameter set
    if (DIGITS < 2) begin : g_bad_digits
        $error("DIGITS must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("BLANK_CYCLES must be at least 1");
    end
    if (BRIGHT_WIDTH > SLOT_WIDTH) begin : g_bad_bright
        $error("BRIGHT_WIDTH must not exceed SLOT_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DIGIT_BITS-1:0]   digit;
    logic [DIGIT_BITS-1:0]   digit_next;
    logic [BLANK_BITS-1:0]   blank_count;
    logic [BLANK_BITS-1:0]   blank_next;
    logic [SLOT_WIDTH-1:0]   slot_count;
    logic [SLOT_WIDTH-1:0]   slot_next;
    logic                    frame_start_next;

    logic [4*DIGITS-1:0]     shadow;
    logic [4*DIGITS-1:0]     active;
    logic [4*DIGITS-1:0]     active_next;
    logic                    pending;
    logic                    commit;
    logic [SLOT_WIDTH-1:0]   threshold;
    logic                    drive_on;
    logic [3:0]              nibble_next;
    logic [DIGITS-1:0]       anodes_next;
    logic [6:0]              segments_next;

    // Standard hex font, active-low gfedcba
    function automatic logic [6:0] hex_to_segments(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // Scan state, digit index and the blank/slot counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            digit       <= '0;
            blank_count <= '0;
            slot_count  <= '0;
        end else begin
            state       <= state_next;
            digit       <= digit_next;
            blank_count <= blank_next;
            slot_count  <= slot_next;
        end
    end

    // Next-state logic: blank gap, drive slot, digit advance and frame wrap
    always_comb begin
        state_next       = state;
        digit_next       = digit;
        blank_next       = blank_count;
        slot_next        = slot_count;
        frame_start_next = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            digit_next = '0;
            blank_next = '0;
            slot_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next       = BLANK;
                    digit_next       = '0;
                    blank_next       = '0;
                    slot_next        = '0;
                    frame_start_next = 1'b1;
                end
                BLANK: begin
                    if (blank_count == LAST_BLANK) begin
                        state_next = DRIVE;
                        blank_next = '0;
                        slot_next  = '0;
                    end else begin
                        blank_next = blank_count + 1'b1;
                    end
                end
                DRIVE: begin
                    if (slot_count == LAST_SLOT) begin
                        state_next = BLANK;
                        slot_next  = '0;
                        blank_next = '0;
                        if (digit == LAST_DIGIT) begin
                            digit_next       = '0;
                            frame_start_next = 1'b1;
                        end else begin
                            digit_next = digit + 1'b1;
                        end
                    end else begin
                        slot_next = slot_count + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    digit_next = '0;
                    blank_next = '0;
                    slot_next  = '0;
                end
            endcase
        end
    end

    // Output pre-decode from next-state values so the pins are registered
    always_comb begin
        commit      = frame_start_next && pending;
        active_next = commit ? shadow : active;
        threshold   = SLOT_WIDTH'(brightness) << BRIGHT_SHIFT;
        drive_on    = (state_next == DRIVE) && (slot_next < threshold);

        nibble_next = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_next == DIGIT_BITS'(i)) begin
                nibble_next = active_next[4*i +: 4];
            end
        end

        anodes_next = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (drive_on && (digit_next == DIGIT_BITS'(i))) begin
                anodes_next[i] = 1'b0;
            end
        end

        segments_next = (state_next == IDLE) ? '1 : hex_to_segments(nibble_next);
    end

    // Load handshake, commit at frame start, and registered pin outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            loadAck    <= 1'b0;
            frameStart <= 1'b0;
            anodes     <= '1;
            segments   <= '1;
        end else begin
            active     <= active_next;
            loadAck    <= commit;
            frameStart <= frame_start_next;
            anodes     <= anodes_next;
            segments   <= segments_next;
            // pending at the start of the cycle decides capture, so a load on
            // the commit edge itself is dropped
            if (commit) begin
                pending <= 1'b0;
            end else if (load && !pending) begin
                shadow  <= digitValues;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed testbench for seven_segment_scan_controller (4 digits, 16-cycle
// slots, 2 blank cycles) with a cycle-level reference model of the scan.
`timescale 1ns/1ps

module tb_seven_segment_scan_controller;

    localparam int DIGITS       = 4;
    localparam int SLOT_WIDTH   = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int BRIGHT_WIDTH = 4;
    localparam int SLOT_TOTAL   = BLANK_CYCLES + (1 << SLOT_WIDTH);
    localparam int FRAME        = DIGITS * SLOT_TOTAL;

    logic                    clock;
    logic                    reset;
    logic                    enable;
    logic [4*DIGITS-1:0]     digitValues;
    logic                    load;
    logic [BRIGHT_WIDTH-1:0] brightness;
    logic                    loadAck;
    logic [DIGITS-1:0]       anodes;
    logic [6:0]              segments;
    logic                    frameStart;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          k        = 0;
    int          lows     = 0;
    bit          running  = 0;
    bit          fs_m     = 0;
    bit          ack_m    = 0;
    bit          pend_m   = 0;
    logic [15:0] shadow_m = '0;
    logic [15:0] active_m = '0;

    seven_segment_scan_controller #(
        .DIGITS       (DIGITS),
        .SLOT_WIDTH   (SLOT_WIDTH),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BRIGHT_WIDTH (BRIGHT_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .digitValues (digitValues),
        .load        (load),
        .brightness  (brightness),
        .loadAck     (loadAck),
        .anodes      (anodes),
        .segments    (segments),
        .frameStart  (frameStart)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference model with the current inputs, then
    // compare every output just after the edge.
    task automatic cyc();
        logic       pend_before;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int         pos;
        int         d;
        int         c;
        if (!enable) begin
            running = 0; k = 0; fs_m = 0;
        end else if (!running) begin
            running = 1; k = 0; fs_m = 1;
        end else begin
            k = (k + 1) % FRAME; fs_m = (k == 0);
        end
        pend_before = pend_m;
        ack_m = 0;
        if (enable && fs_m && pend_m) begin
            active_m = shadow_m; pend_m = 0; ack_m = 1;
        end
        if (load && !pend_before) begin
            shadow_m = digitValues; pend_m = 1;
        end
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        if (running) begin
            pos = k % SLOT_TOTAL;
            d   = k / SLOT_TOTAL;
            exp_seg = seg_of(active_m[4*d +: 4]);
            if (pos >= BLANK_CYCLES) begin
                c = pos - BLANK_CYCLES;
                if (c < int'(brightness) * (1 << (SLOT_WIDTH - BRIGHT_WIDTH)))
                    exp_an = ~(4'd1 << d);
            end
        end
        @(posedge clock);
        #1;
        check("model_anodes", 16'(anodes), 16'(exp_an));
        check("model_segments", 16'(segments), 16'(exp_seg));
        check("model_frameStart", 16'(frameStart), 16'(fs_m));
        check("model_loadAck", 16'(loadAck), 16'(ack_m));
        if (anodes != 4'hF) lows++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        digitValues = '0; brightness = 4'd15;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_anodes", 16'(anodes), 16'h000F);
        check("rst_segments", 16'(segments), 16'h007F);
        check("rst_loadAck", 16'(loadAck), 16'h0000);
        check("rst_frameStart", 16'(frameStart), 16'h0000);
        reset = 1'b0;
        cyc();
        check("idle_anodes", 16'(anodes), 16'h000F);

        // Enable: first frame, active value 0x0000
        enable = 1'b1;
        cyc();                                               // k=0
        check("first_fs", 16'(frameStart), 16'h0001);
        check("first_anodes", 16'(anodes), 16'h000F);
        check("first_seg", 16'(segments), 16'b1000000);
        run(2);                                              // k=2
        check("first_anode_low", 16'(anodes), 16'b1110);
        run(15);                                             // k=17
        check("slot_tail_off", 16'(anodes), 16'b1111);
        run(3);                                              // k=20
        check("digit1_drive", 16'(anodes), 16'b1101);
        run(51);                                             // k=71
        check("no_fs_k71", 16'(frameStart), 16'h0000);
        cyc();                                               // k=0
        check("fs_period_72", 16'(frameStart), 16'h0001);

        // Single load mid-frame, commit at next frame start
        run(30);                                             // k=30
        load = 1'b1; digitValues = 16'h8A10;
        cyc();                                               // k=31 capture
        load = 1'b0; digitValues = 16'h1234;
        run(40);                                             // k=71
        check("old_value_held", 16'(segments), 16'b1000000);
        check("no_early_ack", 16'(loadAck), 16'h0000);
        cyc();                                               // k=0 commit
        check("ack_pulse", 16'(loadAck), 16'h0001);
        check("digit0_is_0", 16'(segments), 16'b1000000);
        cyc();                                               // k=1
        check("ack_one_cycle", 16'(loadAck), 16'h0000);
        run(19);                                             // k=20
        check("digit1_is_1", 16'(segments), 16'b1111001);
        run(18);                                             // k=38
        check("digit2_is_A", 16'(segments), 16'b0001000);
        run(18);                                             // k=56
        check("digit3_is_8", 16'(segments), 16'b0000000);
        run(15);                                             // k=71

        // Load held high with changing values: first capture wins
        load = 1'b1; digitValues = 16'h1111;
        cyc();                                               // k=0 capture 1111
        check("no_ack_on_capture", 16'(loadAck), 16'h0000);
        digitValues = 16'h2222; cyc();
        digitValues = 16'h3333; cyc();                       // k=2
        run(69);                                             // k=71
        digitValues = 16'h4444;
        cyc();                                               // k=0 commit 1111
        check("held_ack", 16'(loadAck), 16'h0001);
        check("held_first_wins", 16'(segments), 16'b1111001);
        digitValues = 16'h5555;
        cyc();                                               // k=1 capture 5555
        digitValues = 16'h6666;
        run(70);                                             // k=71
        load = 1'b0;
        cyc();                                               // k=0 commit 5555
        check("second_ack", 16'(loadAck), 16'h0001);
        check("second_value", 16'(segments), 16'b0010010);

        // Brightness extremes
        brightness = 4'd0; lows = 0;
        run(72);                                             // k=0
        check("bright0_no_lows", 16'(lows), 16'd0);
        brightness = 4'd4; lows = 0;
        run(18);                                             // k=18
        check("bright4_lows", 16'(lows), 16'd4);

        // Drop enable mid-drive of digit 2, load while disabled
        brightness = 4'd15;
        run(22);                                             // k=40
        check("digit2_driving", 16'(anodes), 16'b1011);
        enable = 1'b0;
        cyc();
        check("disable_anodes", 16'(anodes), 16'h000F);
        check("disable_segments", 16'(segments), 16'h007F);
        load = 1'b1; digitValues = 16'h0F0F;
        cyc();
        load = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();                                               // k=0
        check("reenable_fs", 16'(frameStart), 16'h0001);
        check("reenable_ack", 16'(loadAck), 16'h0001);
        check("reenable_digit0_F", 16'(segments), 16'b0001110);
        run(2);                                              // k=2
        check("reenable_digit0_drive", 16'(anodes), 16'b1110);

        // Asynchronous reset mid-slot with a value pending
        run(3);                                              // k=5
        load = 1'b1; digitValues = 16'hBEEF;
        cyc();                                               // k=6 capture
        load = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_anodes", 16'(anodes), 16'h000F);
        check("async_rst_segments", 16'(segments), 16'h007F);
        running = 0; k = 0; fs_m = 0; ack_m = 0; pend_m = 0; active_m = '0;
        @(posedge clock);
        #1;
        check("rst_hold_anodes", 16'(anodes), 16'h000F);
        check("rst_hold_ack", 16'(loadAck), 16'h0000);
        reset = 1'b0;
        cyc();                                               // k=0
        check("post_rst_fs", 16'(frameStart), 16'h0001);
        check("post_rst_no_ack", 16'(loadAck), 16'h0000);
        check("post_rst_active0", 16'(segments), 16'b1000000);
        run(72);                                             // k=0
        check("post_rst_still_no_ack", 16'(loadAck), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
